// File: rtl/myproject_mul_pkg.sv
// Shared helpers for the pipelined multiplier: product width, operand
// extension, saturation bounds and the rounding constant.
package myproject_mul_pkg;

    // Wide working type; every per-lane quantity fits well inside it.
    localparam int XW = 64;

    typedef logic signed [XW-1:0] wide_t;

    function automatic int calc_pw(int w0, int w1);
        return w0 + w1 + 1;
    endfunction

    // Sign- or zero-extend the low w bits of v to the full working width.
    function automatic wide_t ext_op(logic [XW-1:0] v, int w, bit sgn);
        logic [XW-1:0] hi;
        hi = {XW{1'b1}} << w;
        if (sgn && v[w-1]) begin
            return wide_t'(v | hi);
        end
        return wide_t'(v & ~hi);
    endfunction

    function automatic wide_t sat_max(int w, bit sgn);
        if (sgn) begin
            return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        end
        return (wide_t'(1) <<< w) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(int w, bit sgn);
        if (sgn) begin
            return -(wide_t'(1) <<< (w - 1));
        end
        return wide_t'(0);
    endfunction

    // Half an LSB of the shifted result; zero when nothing is shifted out.
    function automatic wide_t round_const(int s);
        if (s == 0) begin
            return wide_t'(0);
        end
        return wide_t'(1) <<< (s - 1);
    endfunction

endpackage

// File: rtl/myproject_mul_lane.sv
// One multiplier lane: extend, multiply, stage registers, then narrow.
// Ports: clk_i, rst_ni (async low), en_i (per-stage load enable from the
// top), din0_i/din1_i operands, dout_o narrowed result, ovf_o clamp flag.
// MYPROJECT_MUL_PIPE_SAT_EN selects round + saturate narrowing.
module myproject_mul_lane
    import myproject_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 5,
    parameter int DIN1_WIDTH  = 3,
    parameter int DOUT_WIDTH  = 8,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_STAGE-1:0]  en_i,
    input  logic [DIN0_WIDTH-1:0] din0_i,
    input  logic [DIN1_WIDTH-1:0] din1_i,
    output logic [DOUT_WIDTH-1:0] dout_o,
    output logic                  ovf_o
);

    localparam int PW = calc_pw(DIN0_WIDTH, DIN1_WIDTH);

    wide_t         a_x;
    wide_t         b_x;
    wide_t         prod_x;
    wide_t         p_x;
    wide_t         s_x;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] stage_q [NUM_STAGE];

    assign a_x = ext_op({{(XW-DIN0_WIDTH){1'b0}}, din0_i},
                        DIN0_WIDTH, DIN0_SIGNED != 0);
    assign b_x = ext_op({{(XW-DIN1_WIDTH){1'b0}}, din1_i},
                        DIN1_WIDTH, DIN1_SIGNED != 0);

    // The exact product always fits in PW signed bits.
    assign prod_x = a_x * b_x;
    assign prod_d = prod_x[PW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_STAGE; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            if (en_i[0]) begin
                stage_q[0] <= prod_d;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (en_i[k]) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end
    end

    assign p_x = {{(XW-PW){stage_q[NUM_STAGE-1][PW-1]}},
                  stage_q[NUM_STAGE-1]};

`ifdef MYPROJECT_MUL_PIPE_SAT_EN
    // Unsigned clamp range only when neither operand can be negative.
    localparam bit    OSGN = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam wide_t SMAX = sat_max(DOUT_WIDTH, OSGN);
    localparam wide_t SMIN = sat_min(DOUT_WIDTH, OSGN);

    wide_t r_x;

    assign r_x = p_x + round_const(SHIFT);
    assign s_x = r_x >>> SHIFT;

    always_comb begin
        ovf_o  = 1'b0;
        dout_o = s_x[DOUT_WIDTH-1:0];
        if (s_x > SMAX) begin
            ovf_o  = 1'b1;
            dout_o = SMAX[DOUT_WIDTH-1:0];
        end else if (s_x < SMIN) begin
            ovf_o  = 1'b1;
            dout_o = SMIN[DOUT_WIDTH-1:0];
        end
    end
`else
    assign s_x    = p_x >>> SHIFT;
    assign dout_o = s_x[DOUT_WIDTH-1:0];
    assign ovf_o  = 1'b0;
`endif

    logic unused_hi;
    assign unused_hi = ^{prod_x[XW-1:PW], s_x[XW-1:DOUT_WIDTH]};

endmodule

// File: rtl/myproject_mul_pipe.sv
// LANES-wide pipelined multiplier with valid/ready flow control.
// Ports: ap_clk, ap_rst_n (async low), in_valid/in_ready, din0, din1,
// out_valid/out_ready, dout, ovf. Optional MYPROJECT_MUL_PIPE_SAT_EN.
module myproject_mul_pipe
    import myproject_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 5,
    parameter int DIN1_WIDTH  = 3,
    parameter int DOUT_WIDTH  = 8,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2,
    parameter int LANES       = 1,
    parameter int SHIFT       = 0
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DIN0_WIDTH-1:0] din0,
    input  logic [LANES*DIN1_WIDTH-1:0] din1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DOUT_WIDTH-1:0] dout,
    output logic [LANES-1:0]            ovf
);

    localparam int PW = calc_pw(DIN0_WIDTH, DIN1_WIDTH);

    if (NUM_STAGE < 1 || SHIFT < 0 || SHIFT >= PW) begin : g_bad_param
        $fatal(1, "myproject_mul_pipe: bad NUM_STAGE or SHIFT");
    end

    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] valid_d;
    logic [NUM_STAGE-1:0] adv;
    logic [NUM_STAGE-1:0] stage_en;

    // adv[k]: stage k may take a new value this cycle. It ripples back
    // from the output so an empty stage never holds up the ones behind.
    always_comb begin
        adv      = '0;
        stage_en = '0;
        valid_d  = valid_q;
        adv[NUM_STAGE-1] = !valid_q[NUM_STAGE-1] || out_ready;
        for (int k = NUM_STAGE - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
        stage_en[0] = adv[0] && in_valid;
        valid_d[0]  = adv[0] ? in_valid : valid_q[0];
        for (int k = 1; k < NUM_STAGE; k++) begin
            stage_en[k] = adv[k] && valid_q[k-1];
            valid_d[k]  = adv[k] ? valid_q[k-1] : valid_q[k];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[NUM_STAGE-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        myproject_mul_lane #(
            .DIN0_WIDTH  (DIN0_WIDTH),
            .DIN1_WIDTH  (DIN1_WIDTH),
            .DOUT_WIDTH  (DOUT_WIDTH),
            .DIN0_SIGNED (DIN0_SIGNED),
            .DIN1_SIGNED (DIN1_SIGNED),
            .NUM_STAGE   (NUM_STAGE),
            .SHIFT       (SHIFT)
        ) u_lane (
            .clk_i  (ap_clk),
            .rst_ni (ap_rst_n),
            .en_i   (stage_en),
            .din0_i (din0[i*DIN0_WIDTH +: DIN0_WIDTH]),
            .din1_i (din1[i*DIN1_WIDTH +: DIN1_WIDTH]),
            .dout_o (dout[i*DOUT_WIDTH +: DOUT_WIDTH]),
            .ovf_o  (ovf[i])
        );
    end

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Self-checking bench for myproject_mul_pipe over four parameter sets.
// Expected results come from an integer-arithmetic model of the multiply.
module tb_myproject_mul_pipe;

    typedef struct {
        int val;
        bit ov;
        int rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t aq[$];

    // A: default parameters, stream under backpressure.
    logic       a_iv = 0, a_ir, a_ov, a_or = 0;
    logic [4:0] a_d0 = 0;
    logic [2:0] a_d1 = 0;
    logic [7:0] a_do;
    logic [0:0] a_ovf;

    // B: two unsigned lanes, three stages.
    logic        b_iv = 0, b_ir, b_ov, b_or = 1;
    logic [9:0]  b_d0 = 0;
    logic [5:0]  b_d1 = 0;
    logic [15:0] b_do;
    logic [1:0]  b_ovf;

    // C (6-bit out) and D (shift 2) share their inputs.
    logic       s_iv = 0, s_or = 1;
    logic [4:0] s_d0 = 0;
    logic [2:0] s_d1 = 0;
    logic       c_ir, c_ov, d_ir, d_ov;
    logic [5:0] c_do;
    logic [7:0] d_do;
    logic [0:0] c_ovf, d_ovf;

    always #5 clk = ~clk;

    myproject_mul_pipe u_a (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir),
        .din0(a_d0), .din1(a_d1),
        .out_valid(a_ov), .out_ready(a_or),
        .dout(a_do), .ovf(a_ovf)
    );

    myproject_mul_pipe #(
        .DIN1_SIGNED(0), .NUM_STAGE(3), .LANES(2)
    ) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir),
        .din0(b_d0), .din1(b_d1),
        .out_valid(b_ov), .out_ready(b_or),
        .dout(b_do), .ovf(b_ovf)
    );

    myproject_mul_pipe #(.DOUT_WIDTH(6)) u_c (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(s_iv), .in_ready(c_ir),
        .din0(s_d0), .din1(s_d1),
        .out_valid(c_ov), .out_ready(s_or),
        .dout(c_do), .ovf(c_ovf)
    );

    myproject_mul_pipe #(.SHIFT(2)) u_d (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(s_iv), .in_ready(d_ir),
        .din0(s_d0), .din1(s_d1),
        .out_valid(d_ov), .out_ready(s_or),
        .dout(d_do), .ovf(d_ovf)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sv(int x, int w, bit s);
        if (s && x >= (1 << (w - 1))) return x - (1 << w);
        return x;
    endfunction

    // Exact product, optional round + clamp, then keep dw low bits.
    function automatic int ref_res(int a, int b, int dw, int sh,
                                   bit osg, output bit ov);
        longint p;
`ifdef MYPROJECT_MUL_PIPE_SAT_EN
        longint hi, lo;
`endif
        p  = longint'(a) * longint'(b);
        ov = 1'b0;
`ifdef MYPROJECT_MUL_PIPE_SAT_EN
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        p  = p >>> sh;
        hi = osg ? (longint'(1) << (dw - 1)) - 1
                 : (longint'(1) << dw) - 1;
        lo = osg ? -(longint'(1) << (dw - 1)) : 0;
        if (p > hi) begin
            p = hi; ov = 1'b1;
        end else if (p < lo) begin
            p = lo; ov = 1'b1;
        end
`else
        p = p >>> sh;
`endif
        return int'(p & ((longint'(1) << dw) - 1));
    endfunction

    // One cycle on A; occupancy and arrival times model the pipe.
    task automatic a_cycle(bit iv, bit ordy, int d0, int d1);
        bit   exp_ir, exp_ov, ov;
        exp_t e;
        a_iv = iv; a_or = ordy;
        a_d0 = 5'(d0); a_d1 = 3'(d1);
        @(negedge clk);
        exp_ir = (aq.size() < 2) || ordy;
        exp_ov = (aq.size() > 0) && (cyc >= aq[0].rdy);
        chk("a_in_ready", a_ir, exp_ir);
        chk("a_out_valid", a_ov, exp_ov);
        if (exp_ov) begin
            chk("a_dout", a_do, aq[0].val);
            chk("a_ovf", a_ovf, aq[0].ov);
        end
        if (exp_ov && ordy) begin
            void'(aq.pop_front());
            if (aq.size() > 0 && aq[0].rdy < cyc + 1)
                aq[0].rdy = cyc + 1;
        end
        if (iv && exp_ir) begin
            e.val = ref_res(sv(d0 & 31, 5, 0), sv(d1 & 7, 3, 1),
                            8, 0, 1'b1, ov);
            e.ov  = ov;
            e.rdy = cyc + 2;
            aq.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic s_beat(int a, int b, int ec, bit oc, int ed, bit od);
        int n;
        s_d0 = 5'(a); s_d1 = 3'(b); s_iv = 1;
        chk("s_in_ready", {c_ir, d_ir}, 2'b11);
        @(posedge clk); #1;
        s_iv = 0; s_d0 = 5'($urandom); s_d1 = 3'($urandom);
        n = 1;
        while (!c_ov && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("s_latency", n, 2);
        chk("d_out_valid", d_ov, 1);
        chk("c_dout", c_do, ec);
        chk("c_ovf", c_ovf, oc);
        chk("d_dout", d_do, ed);
        chk("d_ovf", d_ovf, od);
        @(posedge clk); #1;
        chk("s_popped", {c_ov, d_ov}, 2'b00);
    endtask

    task automatic b_beat(logic [9:0] d0, logic [5:0] d1,
                          logic [15:0] ed, logic [1:0] eo);
        int n;
        b_d0 = d0; b_d1 = d1; b_iv = 1;
        @(posedge clk); #1;
        b_iv = 0; b_d0 = 10'($urandom); b_d1 = 6'($urandom);
        n = 1;
        while (!b_ov && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("b_latency", n, 3);
        chk("b_dout", b_do, ed);
        chk("b_ovf", b_ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          x0, x1, y0, y1, r0, r1, n;
        bit          o0, o1;
        logic [15:0] e16;
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        #23;
        chk("rst_out_valid", {a_ov, b_ov, c_ov, d_ov}, 4'b0);
        chk("rst_dout_a", a_do, 0);
        chk("rst_dout_b", b_do, 0);
        chk("rst_ovf", {a_ovf, b_ovf, c_ovf, d_ovf}, 5'b0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_in_ready", {a_ir, b_ir, c_ir, d_ir}, 4'b1111);
        @(posedge clk); #1;

        // First beat: 31 * -4 = -124.
        a_cycle(1, 1, 31, 4);
        a_cycle(0, 1, 0, 0);
        chk("a_first_ov", a_ov, 1);
        chk("a_first_dout", a_do, 8'h84);
        chk("a_first_ovf", a_ovf, 0);
        for (int i = 0; i < 12; i++)
            a_cycle(i < 8, pat[i % 4], $urandom, $urandom);
        for (int i = 0; i < 60; i++)
            a_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    $urandom, $urandom);
        n = 0;
        while (aq.size() > 0 && n < 20) begin
            a_cycle(0, 1, 0, 0); n++;
        end
        chk("a_drained", aq.size(), 0);

        // Two lanes, both unsigned.
        b_beat({5'd3, 5'd31}, {3'd7, 3'd7}, {8'd21, 8'd217}, 2'b00);
        for (int i = 0; i < 6; i++) begin
            x0 = $urandom_range(0, 31); x1 = $urandom_range(0, 31);
            y0 = $urandom_range(0, 7);  y1 = $urandom_range(0, 7);
            r0 = ref_res(x0, y0, 8, 0, 1'b0, o0);
            r1 = ref_res(x1, y1, 8, 0, 1'b0, o1);
            e16 = {r1[7:0], r0[7:0]};
            b_beat({5'(x1), 5'(x0)}, {3'(y1), 3'(y0)}, e16, {o1, o0});
        end

`ifdef MYPROJECT_MUL_PIPE_SAT_EN
        s_beat(31, 3, 31, 1, 23, 0);
        s_beat(30, 3, 31, 1, 23, 0);
`else
        s_beat(31, 3, 29, 0, 23, 0);
        s_beat(30, 3, 26, 0, 22, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            x0 = $urandom_range(0, 31); y0 = $urandom_range(0, 7);
            r0 = ref_res(sv(x0, 5, 0), sv(y0, 3, 1), 6, 0, 1'b1, o0);
            r1 = ref_res(sv(x0, 5, 0), sv(y0, 3, 1), 8, 2, 1'b1, o1);
            s_beat(x0, y0, r0, o0, r1, o1);
        end

        // Fill B with out_ready low, then reset mid-stream.
        b_or = 0;
        for (int i = 0; i < 3; i++) begin
            b_iv = 1; b_d0 = 10'($urandom); b_d1 = 6'($urandom);
            @(posedge clk); #1;
        end
        b_iv = 0;
        chk("b_full_ov", b_ov, 1);
        chk("b_full_ir", b_ir, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("b_hold_ov", b_ov, 1);
        #2 rst_n = 0;
        #1;
        chk("b_rst_ov", b_ov, 0);
        chk("b_rst_dout", b_do, 0);
        chk("b_rst_ovf", b_ovf, 0);
        @(negedge clk);
        rst_n = 1;
        b_or = 1;
        #1;
        chk("b_rel_ir", b_ir, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("b_no_stale", b_ov, 0);
            chk("b_post_ir", b_ir, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
